fetch_unit: RTL and testbench

Parametrised instruction-fetch unit; successor to the two-phase combinational fetch split. Owns the architectural fetch PC, issues word requests to a fixed 1-cycle-latency instruction memory, and buffers returned instructions, with their PCs, in a small queue. The queue feeds decode over a valid/ready handshake. Supports back-pressure from decode and branch/jump redirect with flush of queued and in-flight fetches.

---
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: owns fetch PC, issues 1-cycle memory reads, queues {instr,pc} for decode; optional predecode via FETCH_PREDECODE_EN.
// Latency: issue in cycle 0, head valid in cycle 2; one instruction per cycle sustained.
// Backpressure: out_ready low fills the queue and stops issue via count+inflight credit; redirect flushes.
module fetch_unit #(
    parameter int PC_WIDTH    = 9,
    parameter int INSTR_WIDTH = 32,
    parameter int FIFO_DEPTH  = 2,
    parameter int PC_STEP     = 4,
    parameter int RESET_PC    = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   mem_req,
    output logic [PC_WIDTH-1:0]    mem_addr,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic [PC_WIDTH-1:0]    out_next_pc,
    output logic                   out_is_ctrl
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PC_WIDTH-1:0] STEP_C   = PC_WIDTH'(PC_STEP);
    localparam logic [PC_WIDTH-1:0] RST_PC_C = PC_WIDTH'(RESET_PC);
    localparam logic [CNT_W:0]      DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);

    logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
    logic                   inflight_q;
    logic [PC_WIDTH-1:0]    inflight_pc_q;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [INSTR_WIDTH-1:0] instr_q [FIFO_DEPTH];
    logic [PC_WIDTH-1:0]    pc_q    [FIFO_DEPTH];

    logic          pop;
    logic          push;
    logic [CNT_W:0] occ;

    assign out_valid   = !reset && (count_q != '0);
    assign pop         = out_valid && out_ready;
    assign push        = inflight_q && !redirect_valid && !reset;
    assign occ         = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    // A pop this cycle frees the slot the new request will land in next cycle.
    assign mem_req     = !reset && !redirect_valid &&
                         ((occ < DEPTH_C) || ((occ == DEPTH_C) && pop));
    assign mem_addr    = fetch_pc_q;
    assign out_instr   = instr_q[rd_ptr_q];
    assign out_pc      = pc_q[rd_ptr_q];
    assign out_next_pc = out_pc + STEP_C;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (mem_req) fetch_pc_d = fetch_pc_q + STEP_C;
            if (push)    wr_ptr_d   = wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_d   = rd_ptr_q + 1'b1;
            count_d = count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RST_PC_C;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= mem_req;
            if (mem_req) inflight_pc_q <= fetch_pc_q;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr_q] <= mem_rdata;
            pc_q[wr_ptr_q]    <= inflight_pc_q;
        end
    end

`ifdef FETCH_PREDECODE_EN
    logic ctrl_q [FIFO_DEPTH];

    function automatic logic is_ctrl(input logic [INSTR_WIDTH-1:0] instr);
        logic [5:0] op;
        op = instr[31:26];
        return (op == 6'b000100) || (op == 6'b000101) || (op == 6'b000010) ||
               (op == 6'b000011) || ((op == 6'b000000) && (instr[5:0] == 6'b001000));
    endfunction

    always_ff @(posedge clk) begin
        if (push) ctrl_q[wr_ptr_q] <= is_ctrl(mem_rdata);
    end

    assign out_is_ctrl = out_valid && ctrl_q[rd_ptr_q];
`else
    assign out_is_ctrl = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scoreboard of expected {pc,instr,next_pc,ctrl}, drained on each decode handshake.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [8:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [8:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [8:0]  out_pc;
    logic [8:0]  out_next_pc;
    logic        out_is_ctrl;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [8:0]  pc;
        logic [31:0] instr;
        logic [8:0]  nxt;
        logic        ctrl;
    } exp_t;
    exp_t sb[$];

    fetch_unit dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_next_pc(out_next_pc),
        .out_is_ctrl(out_is_ctrl)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [8:0] a);
        case (a)
            9'h100:  return 32'h1000_0003;
            9'h104:  return 32'h0000_0020;
            9'h108:  return 32'h03E0_0008;
            9'h10C:  return 32'h0800_0000;
            default: return {23'b0, a};
        endcase
    endfunction

    function automatic logic ref_ctrl(input logic [31:0] w);
`ifdef FETCH_PREDECODE_EN
        logic [5:0] op;
        op = w[31:26];
        return (op == 6'd4) || (op == 6'd5) || (op == 6'd2) || (op == 6'd3) ||
               ((op == 6'd0) && (w[5:0] == 6'd8));
`else
        return (w == 32'h0) && (w != 32'h0);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_range(input logic [8:0] start, input int n);
        exp_t e;
        logic [8:0] p;
        p = start;
        for (int i = 0; i < n; i++) begin
            e.pc    = p;
            e.instr = memf(p);
            e.nxt   = p + 9'd4;
            e.ctrl  = ref_ctrl(e.instr);
            sb.push_back(e);
            p = p + 9'd4;
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        sb.delete();
        reset = 1'b1;
        out_ready = rdy;
        redirect_valid = 1'b0;
        repeat (2) begin
            #1;
            check("rst_mem_req", 32'(mem_req), 32'd0);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_is_ctrl", 32'(out_is_ctrl), 32'd0);
            nxt();
        end
        reset = 1'b0;
    endtask

    task automatic do_redirect(input logic [8:0] pc);
        sb.delete();
        redirect_valid = 1'b1;
        redirect_pc = pc;
        out_ready = 1'b0;
        #1;
        check("redir_no_issue", 32'(mem_req), 32'd0);
        nxt();
        redirect_valid = 1'b0;
        #1;
        check("redir_flushed", 32'(out_valid), 32'd0);
        check("redir_ctrl_idle", 32'(out_is_ctrl), 32'd0);
        check("redir_issue", 32'(mem_req), 32'd1);
        check("redir_addr", 32'(mem_addr), 32'(pc));
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            nxt();
            n++;
        end
        check("drain_left", 32'(sb.size()), 32'd0);
    endtask

    // Instruction memory: captures the request mid-cycle, presents data for the whole next cycle.
    initial begin
        logic [31:0] cap;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            cap = mem_req ? memf(mem_addr) : 32'h0;
            @(posedge clk);
            #1;
            mem_rdata = cap;
        end
    end

    // Scoreboard drain on every accepted head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("out_pc", 32'(out_pc), 32'(e.pc));
                    check("out_instr", out_instr, e.instr);
                    check("out_next_pc", 32'(out_next_pc), 32'(e.nxt));
                    check("out_is_ctrl", 32'(out_is_ctrl), 32'(e.ctrl));
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;

        // Streaming with decode always ready.
        do_reset(1'b1);
        push_range(9'h000, 8);
        for (int k = 0; k < 10; k++) begin
            #1;
            check("strm_req", 32'(mem_req), 32'd1);
            check("strm_addr", 32'(mem_addr), 32'(4 * k));
            check("strm_valid", 32'(out_valid), 32'(k >= 2));
            nxt();
        end
        wait_empty();
        out_ready = 1'b0;

        // Decode stalled from the start: queue holds pc 0 and 4, issue stops.
        do_reset(1'b0);
        push_range(9'h000, 10);
        for (int k = 0; k < 6; k++) begin
            #1;
            check("stall_req", 32'(mem_req), 32'(k < 2));
            if (k >= 2) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_head_pc", 32'(out_pc), 32'd0);
                check("stall_head_instr", out_instr, 32'd0);
            end
            nxt();
        end
        out_ready = 1'b1;
        #1;
        check("resume_req", 32'(mem_req), 32'd1);
        check("resume_addr", 32'(mem_addr), 32'h8);
        wait_empty();
        out_ready = 1'b0;

        // Redirect with one queued entry and one response in flight.
        do_reset(1'b0);
        nxt();
        nxt();
        do_redirect(9'h040);
        push_range(9'h040, 6);
        out_ready = 1'b1;
        wait_empty();
        out_ready = 1'b0;

        // PC wrap at the top of the 9-bit space.
        do_redirect(9'h1F8);
        push_range(9'h1F8, 4);
        out_ready = 1'b1;
        nxt();
        #1;
        check("wrap_addr_1fc", 32'(mem_addr), 32'h1FC);
        nxt();
        #1;
        check("wrap_addr_000", 32'(mem_addr), 32'h000);
        wait_empty();
        out_ready = 1'b0;

        // Reset with a full queue, then restart from RESET_PC.
        repeat (4) nxt();
        #1;
        check("full_valid", 32'(out_valid), 32'd1);
        check("full_no_req", 32'(mem_req), 32'd0);
        do_reset(1'b0);
        #1;
        check("restart_req", 32'(mem_req), 32'd1);
        check("restart_addr", 32'(mem_addr), 32'h000);
        push_range(9'h000, 3);
        out_ready = 1'b1;
        wait_empty();
        out_ready = 1'b0;

        // Predecode: beq, add, jr, j.
        do_redirect(9'h100);
        push_range(9'h100, 4);
        out_ready = 1'b1;
        wait_empty();
        out_ready = 1'b0;
        nxt();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
